// File: rtl/sub_8bit_serial.sv
// Bit-serial subtractor: accepts a, b, bin with parity bits, ripples one borrow
// stage per cycle LSB first, and presents diff/parity/borrow with valid/ready handshake.
module sub_8bit_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             a_par,
   input  logic             b_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             DIFF,
   output logic             bout,
   output logic             par_err
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             dpar_q, dpar_d;
   logic             bout_q, bout_d;
   logic             perr_q, perr_d;

   logic             abit, bbit, dbit, brw_nxt;

   always_comb begin
      abit    = a_q[cnt_q];
      bbit    = b_q[cnt_q];
      dbit    = abit ^ bbit ^ brw_q;
      brw_nxt = (~abit & bbit) | (~(abit ^ bbit) & brw_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      dpar_d  = dpar_q;
      bout_d  = bout_q;
      perr_d  = perr_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               perr_d  = ((^a) != a_par) | ((^b) != b_par);
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d[cnt_q] = dbit;
            brw_d        = brw_nxt;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               diff_d  = acc_d;
               dpar_d  = ^acc_d;
               bout_d  = brw_nxt;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            // Results hold here; the return edge never doubles as an accept.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         dpar_q  <= 1'b0;
         bout_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         dpar_q  <= dpar_d;
         bout_q  <= bout_d;
         perr_q  <= perr_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign diff      = diff_q;
   assign DIFF      = dpar_q;
   assign bout      = bout_q;
   assign par_err   = perr_q;

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Self-checking bench for sub_8bit_serial: directed corner cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic reference.
module tb_sub_8bit_serial;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       a_par;
   logic       b_par;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       DIFF;
   logic       bout;
   logic       par_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_diff;
   logic       exp_dpar;
   logic       exp_bout;
   logic       exp_perr;

   sub_8bit_serial #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .a_par     (a_par),
      .b_par     (b_par),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .DIFF      (DIFF),
      .bout      (bout),
      .par_err   (par_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand set.
   task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                        input logic map, input logic mbp);
      int r;
      r        = int'(ma) - int'(mb) - int'(mbin);
      exp_diff = 8'(r);
      exp_dpar = ^exp_diff;
      exp_bout = (r < 0);
      exp_perr = ((^ma) != map) || ((^mb) != mbp);
   endtask

   // Drive an operand set at a negedge; returns just after the accept edge.
   task automatic start_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                           input logic tbin, input logic tap, input logic tbp);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
      a        = ta;
      b        = tb_;
      bin      = tbin;
      a_par    = tap;
      b_par    = tbp;
      in_valid = 1'b1;
      model(ta, tb_, tbin, tap, tbp);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".busy"}, 32'(in_ready), 32'(0));
   endtask

   // Waits for out_valid with a bound, scrambling ignored inputs meanwhile.
   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         a        = 8'($urandom);
         b        = 8'($urandom);
         bin      = 1'($urandom);
         a_par    = 1'($urandom);
         b_par    = 1'($urandom);
         in_valid = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, 32'(cyc), 32'(8));
      chk({tag, ".diff"}, 32'(diff), 32'(exp_diff));
      chk({tag, ".DIFF"}, 32'(DIFF), 32'(exp_dpar));
      chk({tag, ".bout"}, 32'(bout), 32'(exp_bout));
      chk({tag, ".par_err"}, 32'(par_err), 32'(exp_perr));
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".idle_rdy"}, 32'(in_ready), 32'(1));
      chk({tag, ".idle_ov"}, 32'(out_valid), 32'(0));
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rbin, rap, rbp;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      a_par     = 1'b0;
      b_par     = 1'b0;
      out_ready = 1'b0;

      #2;
      chk("rst.in_ready", 32'(in_ready), 32'(1));
      chk("rst.out_valid", 32'(out_valid), 32'(0));
      chk("rst.outs", 32'({diff, DIFF, bout, par_err}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases.
      start_op("d1", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
      chk("d1.model", 32'({exp_diff, exp_dpar, exp_bout}), 32'({8'h02, 1'b1, 1'b0}));
      wait_done("d1");
      finish_op("d1");

      start_op("d2", 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
      wait_done("d2");
      chk("d2.lit", 32'({diff, DIFF, bout}), 32'({8'hFF, 1'b0, 1'b1}));
      finish_op("d2");

      start_op("d3", 8'h80, 8'h7F, 1'b1, 1'b1, 1'b1);
      wait_done("d3");
      chk("d3.lit", 32'({diff, DIFF, bout}), 32'({8'h00, 1'b0, 1'b0}));
      finish_op("d3");

      start_op("d4", 8'h0F, 8'h01, 1'b0, 1'b1, 1'b1);
      wait_done("d4");
      chk("d4.lit", 32'({diff, bout, par_err}), 32'({8'h0E, 1'b0, 1'b1}));
      finish_op("d4");

      // Backpressure with a new operand set waiting on the input.
      start_op("bp", 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
      wait_done("bp");
      ra = 8'h37; rb = 8'h58; rbin = 1'b0;
      a = ra; b = rb; bin = rbin; a_par = ^ra; b_par = ^rb;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.hold_rdy", 32'(in_ready), 32'(0));
         chk("bp.hold_ov", 32'(out_valid), 32'(1));
         chk("bp.hold_res", 32'({diff, DIFF, bout, par_err}),
             32'({exp_diff, exp_dpar, exp_bout, exp_perr}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp.no_accept", 32'(in_ready), 32'(1));
      chk("bp.ov_low", 32'(out_valid), 32'(0));
      model(ra, rb, rbin, ^ra, ^rb);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.accepted", 32'(in_ready), 32'(0));
      wait_done("bp2");
      finish_op("bp2");

      // Reset pulsed during CALC cycle 4.
      start_op("rs", 8'hC3, 8'h12, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rs.in_ready", 32'(in_ready), 32'(1));
      chk("rs.out_valid", 32'(out_valid), 32'(0));
      chk("rs.outs", 32'({diff, DIFF, bout, par_err}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("rs.no_ov", 32'(out_valid), 32'(0));
      end
      start_op("rs2", 8'h44, 8'h45, 1'b1, 1'b0, 1'b1);
      wait_done("rs2");
      finish_op("rs2");

      // Accept on the very first edge after reset release.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start_op("rs3", 8'h9A, 8'h21, 1'b0, 1'b0, 1'b0);
      wait_done("rs3");
      finish_op("rs3");

      // Randomized operands, occasional parity corruption and held results.
      for (int n = 0; n < 40; n++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rbin = 1'($urandom);
         rap  = (^ra) ^ ($urandom_range(0, 3) == 0);
         rbp  = (^rb) ^ ($urandom_range(0, 3) == 0);
         start_op("rnd", ra, rb, rbin, rap, rbp);
         wait_done("rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rnd.held", 32'({out_valid, diff, bout, par_err}),
             32'({1'b1, exp_diff, exp_bout, exp_perr}));
         finish_op("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
